// File: rtl/lcd_cmd_ctrl.sv
// lcd_cmd_ctrl
//   Buffers CPU-written LCD command words in a small FIFO and sequences each
//   one onto an HD44780-style 8-bit parallel bus. Each command goes through
//   setup, enable-pulse and hold phases, then an execution wait. The wait is
//   long for clear (0x01) and home (0x02/0x03) and normal for everything else.
//
//   Optional feature: define LCD_INIT_EN to add a power-up INIT sequence. After
//   reset the block waits T_POWERUP cycles and then sends 0x38, 0x38, 0x0C,
//   0x01 and 0x06 before it serves the FIFO.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   cmd_valid_i  command write strobe
//   cmd_data_i   command word: [31] ON, [9] RS, [7:0] DATA
//   cmd_ready_o  FIFO not full
//   lcd_on_o     LCD power/backlight enable (updated on every accepted push)
//   lcd_rs_o     register select
//   lcd_rw_o     read/write select, always 0 (write-only)
//   lcd_en_o     enable strobe
//   lcd_data_o   LCD data bus
//   busy_o       sequencer active or FIFO non-empty
//   level_o      FIFO occupancy
module lcd_cmd_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_EN_HIGH   = 12,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 1850,
    parameter int unsigned T_EXEC_LONG = 76000,
    parameter int unsigned T_POWERUP   = 2000000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cmd_valid_i,
    input  logic [31:0]                   cmd_data_i,
    output logic                          cmd_ready_o,
    output logic                          lcd_on_o,
    output logic                          lcd_rs_o,
    output logic                          lcd_rw_o,
    output logic                          lcd_en_o,
    output logic [7:0]                    lcd_data_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned M1   = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
    localparam int unsigned M2   = (M1 > T_HOLD) ? M1 : T_HOLD;
    localparam int unsigned M3   = (M2 > T_EXEC) ? M2 : T_EXEC;
    localparam int unsigned M4   = (M3 > T_EXEC_LONG) ? M3 : T_EXEC_LONG;
    localparam int unsigned CMAX = (M4 > T_POWERUP) ? M4 : T_POWERUP;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
`ifdef LCD_INIT_EN
        ,
        ST_INIT
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [8:0]      mem_q [FIFO_DEPTH];
    logic [8:0]      mem_d [FIFO_DEPTH];
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            en_q, en_d;
    logic            on_q, on_d;
`ifdef LCD_INIT_EN
    logic [2:0]      init_idx_q, init_idx_d;
    logic            in_init_q, in_init_d;
`endif

    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            cnt_done;
    logic            is_long;
    logic [8:0]      head;
    logic            unused_bits;

    assign unused_bits = ^{cmd_data_i[30:10], cmd_data_i[8]};

`ifdef LCD_INIT_EN
    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h38;
            3'd2:    return 8'h0C;
            3'd3:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    // The extra pointer bit separates full (MSBs differ) from empty (equal).
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop      = (state_q == ST_IDLE) && !empty;
    // A push into a full FIFO is still taken when a pop frees a slot at the same edge.
    assign push     = cmd_valid_i && (!full || pop);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign cnt_done = (cnt_q <= CW'(1));
    assign is_long  = !rs_q && ((data_q == 8'h01) || (data_q[7:1] == 7'b0000001));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        rs_d     = rs_q;
        data_d   = data_q;
        en_d     = en_q;
        on_d     = on_q;
`ifdef LCD_INIT_EN
        init_idx_d = init_idx_q;
        in_init_d  = in_init_q;
`endif

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {cmd_data_i[9], cmd_data_i[7:0]};
            wr_ptr_d = wr_ptr_q + 1'b1;
            on_d     = cmd_data_i[31];
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    rs_d    = head[8];
                    data_d  = head[7:0];
                    cnt_d   = CW'(T_SETUP);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_done) begin
                    en_d    = 1'b1;
                    cnt_d   = CW'(T_EN_HIGH);
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_done) begin
                    en_d    = 1'b0;
                    cnt_d   = CW'(T_HOLD);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_done) begin
                    cnt_d   = is_long ? CW'(T_EXEC_LONG) : CW'(T_EXEC);
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_done) begin
                    state_d = ST_IDLE;
`ifdef LCD_INIT_EN
                    // Between init commands, go back to INIT with a one-cycle
                    // count so that the next command loads on the following edge.
                    if (in_init_q) begin
                        if (init_idx_q == 3'd4) begin
                            in_init_d = 1'b0;
                        end else begin
                            init_idx_d = init_idx_q + 3'd1;
                            cnt_d      = CW'(1);
                            state_d    = ST_INIT;
                        end
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef LCD_INIT_EN
            ST_INIT: begin
                if (cnt_done) begin
                    rs_d    = 1'b0;
                    data_d  = init_cmd(init_idx_q);
                    cnt_d   = CW'(T_SETUP);
                    state_d = ST_SETUP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rs_q     <= 1'b0;
            data_q   <= '0;
            en_q     <= 1'b0;
`ifdef LCD_INIT_EN
            state_q    <= ST_INIT;
            cnt_q      <= CW'(T_POWERUP);
            on_q       <= 1'b1;
            init_idx_q <= '0;
            in_init_q  <= 1'b1;
`else
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            on_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            en_q     <= en_d;
            on_q     <= on_d;
`ifdef LCD_INIT_EN
            init_idx_q <= init_idx_d;
            in_init_q  <= in_init_d;
`endif
        end
    end

    assign cmd_ready_o = !full;
    assign lcd_on_o    = on_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_en_o    = en_q;
    assign lcd_data_o  = data_q;
    assign busy_o      = (state_q != ST_IDLE) || !empty;
    assign level_o     = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// tb_lcd_cmd_ctrl
//   Self-checking bench for lcd_cmd_ctrl. It applies directed sequences and
//   then randomized stimulus. The reference model works on a timeline: it
//   keeps a command queue plus the edge numbers at which EN rises and falls
//   and at which the block returns to idle. Every output is compared on each
//   falling clock edge.
//   Honors LCD_INIT_EN, the same macro as the design.
module tb_lcd_cmd_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TS    = 2;
    localparam int unsigned TEN   = 4;
    localparam int unsigned TH    = 2;
    localparam int unsigned TX    = 10;
    localparam int unsigned TXL   = 40;
    localparam int unsigned TPU   = 5;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic [31:0] cmd_data_i = '0;
    logic        cmd_ready_o;
    logic        lcd_on_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic        lcd_en_o;
    logic [7:0]  lcd_data_o;
    logic        busy_o;
    logic [2:0]  level_o;

    lcd_cmd_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .T_SETUP     (TS),
        .T_EN_HIGH   (TEN),
        .T_HOLD      (TH),
        .T_EXEC      (TX),
        .T_EXEC_LONG (TXL),
        .T_POWERUP   (TPU)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_ready_o (cmd_ready_o),
        .lcd_on_o    (lcd_on_o),
        .lcd_rs_o    (lcd_rs_o),
        .lcd_rw_o    (lcd_rw_o),
        .lcd_en_o    (lcd_en_o),
        .lcd_data_o  (lcd_data_o),
        .busy_o      (busy_o),
        .level_o     (level_o)
    );

    always #5 clk = ~clk;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    // Reference model state
    logic [8:0] q[$];
    logic [7:0] init_q[$];
    int         now       = 0;
    int         en_rise   = 0;
    int         en_fall   = 0;
    int         idle_edge = 0;
    logic       m_rs      = 1'b0;
    logic [7:0] m_data    = '0;
    logic       m_on      = 1'b0;
    bit         armed     = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, now, got, exp);
        end
    endtask

    function automatic int unsigned wait_len(input logic rs, input logic [7:0] d);
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return TXL;
        return TX;
    endfunction

    function automatic bit model_busy();
        return (now < idle_edge) || (q.size() != 0) || (init_q.size() != 0);
    endfunction

    task automatic check_outputs();
        bit en_exp;
        en_exp = (now >= en_rise) && (now < en_fall);
        check_eq("en",    32'(lcd_en_o),    32'(en_exp));
        check_eq("rs",    32'(lcd_rs_o),    32'(m_rs));
        check_eq("data",  32'(lcd_data_o),  32'(m_data));
        check_eq("on",    32'(lcd_on_o),    32'(m_on));
        check_eq("rw",    32'(lcd_rw_o),    32'(1'b0));
        check_eq("busy",  32'(busy_o),      32'(model_busy()));
        check_eq("level", 32'(level_o),     32'(q.size()));
        check_eq("ready", 32'(cmd_ready_o), 32'(q.size() < DEPTH));
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [31:0] d);
        logic [8:0] cmd;
        bit         got_cmd;
        bit         popped_cpu;
        now++;
        if (r) begin
            q.delete();
            init_q.delete();
            m_rs = 1'b0;
            m_data = '0;
            en_rise = 0;
            en_fall = 0;
            idle_edge = now;
            m_on = 1'b0;
`ifdef LCD_INIT_EN
            m_on = 1'b1;
            init_q = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
            idle_edge = now + int'(TPU) - 1;
`endif
            armed = 1'b1;
            return;
        end
        got_cmd = 1'b0;
        popped_cpu = 1'b0;
        cmd = '0;
        if (now > idle_edge) begin
            if (init_q.size() != 0) begin
                cmd = {1'b0, init_q.pop_front()};
                got_cmd = 1'b1;
            end else if (q.size() != 0) begin
                cmd = q.pop_front();
                got_cmd = 1'b1;
                popped_cpu = 1'b1;
            end
        end
        if (got_cmd) begin
            m_rs = cmd[8];
            m_data = cmd[7:0];
            en_rise = now + int'(TS);
            en_fall = en_rise + int'(TEN);
            idle_edge = en_fall + int'(TH) + int'(wait_len(cmd[8], cmd[7:0]));
        end
        if (v && (q.size() < DEPTH || popped_cpu)) begin
            q.push_back({d[9], d[7:0]});
            m_on = d[31];
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [31:0] d);
        @(negedge clk);
        if (armed) check_outputs();
        rst_i = r;
        cmd_valid_i = v;
        cmd_data_i = d;
        model_edge(r, v, d);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && model_busy(); i++) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
    endtask

    function automatic logic [31:0] rand_cmd();
        logic [31:0] w;
        int unsigned sel;
        w = $urandom;
        sel = $urandom_range(0, 7);
        if (sel == 0) begin
            w[9] = 1'b0;
            w[7:0] = 8'h01;
        end else if (sel == 1) begin
            w[9] = 1'b0;
            w[7:0] = 8'h02 | 8'($urandom_range(0, 1));
        end else if (sel == 2) begin
            w[9] = 1'b0;
            w[7:0] = 8'h04;
        end
        return w;
    endfunction

    initial begin
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        wait_idle();

        // Single data write, then clear / home / normal command timing
        cycle(1'b0, 1'b1, 32'h8000_0241);
        wait_idle();
        cycle(1'b0, 1'b1, 32'h8000_0001);
        wait_idle();
        cycle(1'b0, 1'b1, 32'h0000_0002);
        wait_idle();
        cycle(1'b0, 1'b1, 32'h8000_0004);
        wait_idle();

        // Back-to-back burst, then a held strobe while the FIFO is full
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'h8000_0250 + 32'(i));
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 32'h0000_0360 + 32'(i));
        cycle(1'b0, 1'b0, '0);
        wait_idle();

        // Reset during the enable pulse with commands queued
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h8000_0270 + 32'(i));
        for (int i = 0; i < 50 && !((now + 1 > en_rise) && (now + 1 < en_fall)); i++)
            cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, '0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0)
                cycle(1'b1, 1'b0, '0);
            else
                cycle(1'b0, ($urandom_range(0, 9) < 3), rand_cmd());
        end
        wait_idle();
        @(negedge clk);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
